// File: rtl/spi_sclk_gen_if.sv
// Handshake, configuration and strobe bundle between spi_sclk_gen and its SPI datapath.
// CS_N is present only when SPI_SCLK_CS_GEN_EN is defined.
interface spi_sclk_gen_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] nclk;
    logic             cpol;
    logic             cpha;
    logic             stop;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             SCLK;
    logic             sample;
    logic             shift;
    logic [CNT_W-1:0] cyc_cnt;
`ifdef SPI_SCLK_CS_GEN_EN
    logic             CS_N;

    modport master (
        output start, div, nclk, cpol, cpha, stop,
        input  busy, done, aborted, SCLK, sample, shift, cyc_cnt, CS_N
    );

    modport slave (
        input  start, div, nclk, cpol, cpha, stop,
        output busy, done, aborted, SCLK, sample, shift, cyc_cnt, CS_N
    );
`else
    modport master (
        output start, div, nclk, cpol, cpha, stop,
        input  busy, done, aborted, SCLK, sample, shift, cyc_cnt
    );

    modport slave (
        input  start, div, nclk, cpol, cpha, stop,
        output busy, done, aborted, SCLK, sample, shift, cyc_cnt
    );
`endif
endinterface

// File: rtl/spi_sclk_gen.sv
// Countable SCLK burst generator with CPOL/CPHA modes and sample/shift strobes.
// Optional chip-select setup/hold sequencing is enabled by defining SPI_SCLK_CS_GEN_EN.
module spi_sclk_gen #(
    parameter int DIV_W    = 8,
    parameter int CNT_W    = 16,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic          CLK,
    input  logic          RST,
    spi_sclk_gen_if.slave bus
);
    localparam logic [2:0]       ST_IDLE  = 3'd0;
    localparam logic [2:0]       ST_RUN   = 3'd1;
    localparam logic [2:0]       ST_DONE  = 3'd2;
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    if (CS_SETUP < 1 || CS_HOLD < 1 || CS_SETUP > 256 || CS_HOLD > 256) begin : g_cs_param_check
        $error("spi_sclk_gen: CS_SETUP and CS_HOLD must lie in 1..256");
    end

`ifdef SPI_SCLK_CS_GEN_EN
    localparam logic [2:0] ST_SETUP   = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

    logic       cs_n_r;
    logic [7:0] pc_r;
    logic       abort_pend_r;
`endif

    logic [2:0]       state_r;
    logic [DIV_W-1:0] hc_r;
    logic [DIV_W-1:0] div_r;
    logic [CNT_W-1:0] nclk_r;
    logic             cpol_r;
    logic             cpha_r;
    logic             phase_r;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic             sclk_r;
    logic             busy_r;
    logic             done_r;
    logic             aborted_r;
    logic             sample_r;
    logic             shift_r;
    logic             hc_wrap_s;
    logic             last_trail_s;

    // phase_r set means the next SCLK toggle is a trailing edge
    assign hc_wrap_s    = (hc_r == div_r);
    assign last_trail_s = hc_wrap_s && phase_r && ((cyc_cnt_r + CNT_ONE) == nclk_r);

    // Burst sequencer: handshake, half-period counting, SCLK and strobe generation
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            hc_r         <= DIV_ZERO;
            div_r        <= DIV_ZERO;
            nclk_r       <= CNT_ZERO;
            cpol_r       <= 1'b0;
            cpha_r       <= 1'b0;
            phase_r      <= 1'b0;
            cyc_cnt_r    <= CNT_ZERO;
            sclk_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            sample_r     <= 1'b0;
            shift_r      <= 1'b0;
`ifdef SPI_SCLK_CS_GEN_EN
            cs_n_r       <= 1'b1;
            pc_r         <= 8'd0;
            abort_pend_r <= 1'b0;
`endif
        end else begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            sample_r  <= 1'b0;
            shift_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sclk_r <= bus.cpol;
                    if (bus.start) begin
                        div_r     <= bus.div;
                        nclk_r    <= bus.nclk;
                        cpol_r    <= bus.cpol;
                        cpha_r    <= bus.cpha;
                        cyc_cnt_r <= CNT_ZERO;
                        hc_r      <= DIV_ZERO;
                        phase_r   <= 1'b0;
`ifdef SPI_SCLK_CS_GEN_EN
                        cs_n_r       <= 1'b0;
                        busy_r       <= 1'b1;
                        pc_r         <= 8'd0;
                        abort_pend_r <= 1'b0;
                        state_r      <= ST_SETUP;
`else
                        if (bus.nclk == CNT_ZERO) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= ST_RUN;
                        end
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
`ifdef SPI_SCLK_CS_GEN_EN
                ST_SETUP: begin
                    if (bus.stop) begin
                        pc_r         <= 8'd0;
                        abort_pend_r <= 1'b1;
                        state_r      <= ST_HOLD;
                    end else if (pc_r == SETUP_LAST) begin
                        pc_r    <= 8'd0;
                        hc_r    <= DIV_ZERO;
                        state_r <= (nclk_r == CNT_ZERO) ? ST_HOLD : ST_RUN;
                    end else begin
                        pc_r <= pc_r + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (pc_r == HOLD_LAST) begin
                        cs_n_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        aborted_r <= abort_pend_r;
                        state_r   <= ST_DONE;
                    end else begin
                        pc_r <= pc_r + 8'd1;
                    end
                end
`endif
                ST_RUN: begin
                    // The final trailing edge wins over a coincident stop
                    if (last_trail_s) begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
                        hc_r      <= DIV_ZERO;
                        sclk_r    <= cpol_r;
                        sample_r  <= cpha_r;
                        shift_r   <= ~cpha_r;
`ifdef SPI_SCLK_CS_GEN_EN
                        pc_r      <= 8'd0;
                        state_r   <= ST_HOLD;
`else
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
`endif
                    end else if (bus.stop) begin
                        sclk_r <= cpol_r;
`ifdef SPI_SCLK_CS_GEN_EN
                        pc_r         <= 8'd0;
                        abort_pend_r <= 1'b1;
                        state_r      <= ST_HOLD;
`else
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        aborted_r <= 1'b1;
                        state_r   <= ST_DONE;
`endif
                    end else if (hc_wrap_s) begin
                        hc_r    <= DIV_ZERO;
                        sclk_r  <= ~sclk_r;
                        phase_r <= ~phase_r;
                        if (phase_r) begin
                            cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
                            sample_r  <= cpha_r;
                            shift_r   <= ~cpha_r;
                        end else begin
                            sample_r  <= ~cpha_r;
                            shift_r   <= cpha_r;
                        end
                    end else begin
                        hc_r <= hc_r + DIV_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    sclk_r  <= cpol_r;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.aborted = aborted_r;
    assign bus.SCLK    = sclk_r;
    assign bus.sample  = sample_r;
    assign bus.shift   = shift_r;
    assign bus.cyc_cnt = cyc_cnt_r;
`ifdef SPI_SCLK_CS_GEN_EN
    assign bus.CS_N    = cs_n_r;
`endif
endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
- Synthesizable, parametrised serial-clock generator for the FM25Q-series SPI flash interface.
- Derives SCLK from the system clock with a programmable divider, SPI mode (CPOL/CPHA) and burst length.
- Provides a start/busy/done handshake and sample/shift strobes to the shift-register datapath.
- Replaces free-running, enable-gated bench clocking with a cycle-exact, countable burst generator.

Parameters:
- DIV_W, 8, width of the divider input; half-period = div+1 CLK cycles.
- CNT_W, 16, width of the SCLK-cycle count input and the completed-cycle counter.
- CS_SETUP, 2, CLK cycles from CS_N fall to the first SCLK phase (optional feature only).
- CS_HOLD, 2, CLK cycles from the last trailing edge to CS_N rise (optional feature only).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  request a burst; sampled only in IDLE.
- div  in  DIV_W  half-period minus 1; latched at accept.
- nclk  in  CNT_W  number of SCLK cycles in the burst; latched at accept.
- cpol  in  1  SCLK idle level; latched at accept.
- cpha  in  1  0: sample on leading edge / shift on trailing; 1: the reverse. Latched at accept.
- stop  in  1  abort the burst in progress.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  qualifies done; high when the burst ended by stop.
- SCLK  out  1  registered serial clock.
- sample  out  1  one-cycle strobe coincident with the sampling edge.
- shift  out  1  one-cycle strobe coincident with the shifting edge.
- cyc_cnt  out  CNT_W  completed SCLK cycles in the current or last burst.

Behaviour:
- Reset (asynchronous): all outputs 0, SCLK=0, state IDLE, latched parameters 0.
- States: IDLE, RUN, DONE (plus SETUP and HOLD with the optional feature).
- IDLE:
  - SCLK follows cpol with one cycle of register delay.
  - start=1 at edge t0 latches div/nclk/cpol/cpha, clears cyc_cnt and the half-period counter hc.
  - If nclk=0: go to DONE (busy never asserted). Otherwise: busy=1, go to RUN.
- RUN:
  - hc increments each cycle; at hc==div, hc returns to 0 and SCLK toggles.
  - Leading edge i (i=1..nclk) registered at t0+(2i-1)(div+1); trailing edge i at t0+2i(div+1).
  - cyc_cnt increments on each trailing edge.
  - cpha=0: sample pulses with leading edges, shift with trailing. cpha=1: shift with leading, sample with trailing.
  - On the final trailing edge: SCLK=cpol, busy=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Latency: done high in the cycle after edge t0+2·nclk·(div+1).
- div=0: SCLK = CLK/2.
- stop in RUN: at the next edge SCLK=cpol, no strobe, busy=0, go to DONE with aborted=1 alongside done. cyc_cnt keeps its completed-cycle value.
- stop in IDLE or DONE: ignored.
- Simultaneous stop and final trailing edge: normal completion (aborted=0, strobe issued).
- While busy: start is ignored and input parameter changes have no effect.
- RST asserted mid-burst: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: SPI_SCLK_CS_GEN_EN.
- Defined:
  - Adds port CS_N out 1 (reset value 1).
  - Accept drives CS_N=0, busy=1 and enters SETUP for CS_SETUP cycles, then RUN; all RUN timings shift by CS_SETUP.
  - After the final trailing edge, HOLD for CS_HOLD cycles, then CS_N=1, busy=0, DONE.
  - stop in SETUP or RUN goes to HOLD; aborted=1 with done.
  - nclk=0 still performs SETUP and HOLD.
- Undefined: no CS_N port, no SETUP/HOLD states, latencies exactly as above.

Test Plan:
- div=1, nclk=8, cpol=0, cpha=0, start pulse -> SCLK period 4 CLK; 8 rising edges, first 2 cycles after accept; 8 sample pulses on rising and 8 shift pulses on falling; done 32 cycles after accept; cyc_cnt=8; aborted=0.
- div=0, nclk=3, cpol=1, cpha=1 -> SCLK idles 1; 3 falling leading edges with shift; sample on rising; done 6 cycles after accept; SCLK ends at 1.
- nclk=0, start -> busy stays 0; done high in the cycle right after accept; SCLK never toggles.
- div=3, nclk=16, stop asserted right after the 3rd trailing edge -> SCLK at cpol next edge; done=1 and aborted=1 together; cyc_cnt=3; no further strobes.
- RST pulsed mid-burst (div=2, nclk=10) -> SCLK, busy, strobes and cyc_cnt go 0 without a CLK edge; no done; a new start after RST release runs a full burst.
- With SPI_SCLK_CS_GEN_EN, CS_SETUP=2, CS_HOLD=2, div=1, nclk=4 -> CS_N low at accept; first leading edge 4 cycles after accept; CS_N high and done 20 cycles after accept; start pulses while busy are ignored.
